jtkcpu_bus: RTL and testbench
=============================

# jtkcpu_bus

Byte-wide memory bus sequencer for the KCPU core. It sits between the external 8-bit memory bus and the control unit. It accepts opcode-fetch, operand-read and write requests from the microcode, splits 16-bit accesses into two big-endian byte cycles, and assembles `op`/`mdata`. It drives `mem_busy` back to the microcode and flags bus timeouts.

## Interface
Parameters:
- TIMEOUT, 16: cen cycles a byte cycle may wait for `bus_ok` before abort (2..255)

Ports:
- rst  in  1  reset; asynchronous, active-high
- clk  in  1  single clock for the whole block
- cen  in  1  clock enable; all state advances only when high
- addr  in  16  access address (PC or effective address), sampled at request acceptance
- ni  in  1  opcode fetch request
- opd  in  1  operand/data read request
- wrq  in  1  write request
- memhi  in  1  16-bit access when high, 8-bit otherwise; sampled with the request
- dout  in  16  write data, sampled at acceptance
- op  out  8  last fetched opcode
- mdata  out  16  last read data
- mem_busy  out  1  access pending or in progress
- buserror  out  1  one-cen-cycle pulse on timeout
- bus_cs  out  1  external bus cycle active
- bus_we  out  1  external write strobe
- bus_addr  out  16  external byte address
- bus_dout  out  8  external write byte
- din  in  8  external read byte
- bus_ok  in  1  external cycle completes on this cen cycle

## Operation
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO.
- Acceptance happens in IDLE on a cen cycle with any request.
  - Priority: ni > wrq > opd. Lower-priority simultaneous requests are dropped.
  - The block latches `addr`, `memhi`, `dout` and the request kind.
- Read, 8-bit or ni: go to RD_HI with `bus_addr=addr`.
  - On completion, opcode fetch loads `op<=din` and leaves mdata unchanged.
  - On completion, an opd read loads `mdata<={8'h00,din}`.
  - ni always performs an 8-bit fetch; `memhi` is ignored.
- Read, 16-bit: RD_HI latches `din` into a holding byte, then RD_LO runs with `bus_addr=addr+1`.
  - On RD_LO completion, `mdata<={hold,din}`. mdata is updated atomically; no half-written value is ever visible.
- Write, 8-bit: WR_HI drives `bus_dout=dout[7:0]` to `addr`.
- Write, 16-bit: WR_HI drives `dout[15:8]` to `addr`, then WR_LO drives `dout[7:0]` to `addr+1`.
- `bus_we` is high in WR states only. `bus_cs` is high in every non-IDLE state.
- Address increment is 16-bit and wraps: FFFFh+1 = 0000h.
- A byte cycle completes on a cen cycle with `bus_ok=1`. The last byte returns the block to IDLE.
- Timeout:
  - A counter clears on every state entry and counts cen cycles with `bus_cs & ~bus_ok`.
  - When it reaches TIMEOUT, `buserror` pulses for one cen cycle and the state returns to IDLE.
  - op and mdata keep their prior values, and the partial access is discarded.
- `mem_busy` = (state != IDLE) | (state == IDLE & (ni|opd|wrq)). It is combinational so the microcode stalls in the request cycle itself.
- Reset: state IDLE; op=00h, mdata=0000h, bus_addr=0000h, bus_dout=00h, bus_cs=0, bus_we=0, buserror=0, counter=0, and mem_busy=0 regardless of requests. Reset applies immediately, even mid-transfer; no write byte is completed after rst rises.

## Timing
- With `bus_ok` tied high and cen=1, taking the acceptance edge as T0:
  - 8-bit read: `bus_cs` is high T0→T1. op/mdata are valid after edge T1. mem_busy is high during cycles T0 and T1, then low.
  - 16-bit read: RD_HI T0→T1, RD_LO T1→T2. mdata is valid after T2. mem_busy is high for 3 cycles.
  - 16-bit write: two bus cycles, at addr and then addr+1. mem_busy is high for 3 cycles.
- With cen low, all registers hold; bus outputs remain static.
- Back-to-back: a request present in the cycle the block returns to IDLE is accepted at the next cen edge. There is no dead cycle beyond the IDLE acceptance cycle.
- buserror is asserted on the edge TIMEOUT cen cycles after the stalled state was entered, and deasserted on the following cen edge.

## Test plan
- Opcode fetch: addr=1234h, ni=1, din=86h, bus_ok=1 -> `bus_addr=1234h`; op=86h one cycle later; mdata unchanged; mem_busy high 2 cycles.
- 16-bit read at wrap: addr=FFFFh, opd=1, memhi=1, din=12h then 34h -> bus_addr FFFFh then 0000h; mdata=1234h only after the second byte.
- 16-bit write with wait: dout=ABCDh, wrq=1, memhi=1, bus_ok low 3 cen cycles per byte -> ABh@addr, CDh@addr+1; bus_we high throughout; mem_busy drops after the second completion.
- Priority: ni, opd and wrq together in IDLE -> only the opcode fetch occurs; no write strobe.
- Timeout: TIMEOUT=4, bus_ok=0 on read -> buserror single pulse 4 cen cycles after entry; return to IDLE; mdata retains its old value.
- Reset mid-transfer: rst asserted during WR_LO -> bus_cs, bus_we and mem_busy are 0 immediately; op=00h and mdata=0000h after release; next request behaves normally.

Source files
------------

// File: rtl/jtkcpu_bus.sv
// KCPU byte-wide memory bus sequencer.
// Splits 16-bit accesses into big-endian byte cycles and assembles op/mdata.
module jtkcpu_bus #(
  parameter int TIMEOUT = 16
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] addr,
  input  logic        ni,
  input  logic        opd,
  input  logic        wrq,
  input  logic        memhi,
  input  logic [15:0] dout,
  output logic [7:0]  op,
  output logic [15:0] mdata,
  output logic        mem_busy,
  output logic        buserror,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  din,
  input  logic        bus_ok
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, WR_HI, WR_LO
  } st_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  st_t        st, st_n;
  logic       acc, acc_wr, tmo;
  logic       fetch, hi;
  logic [7:0] wlo, hold, cnt;

  assign bus_cs   = st != IDLE;
  assign bus_we   = st == WR_HI || st == WR_LO;
  assign mem_busy = ~rst & (bus_cs | ni | opd | wrq);

  // Next-state decode, request arbitration and timeout detection
  always_comb begin
    st_n   = st;
    acc    = 1'b0;
    acc_wr = 1'b0;
    tmo    = 1'b0;
    case (st)
      IDLE: if (ni | wrq | opd) begin
        acc    = 1'b1;
        acc_wr = ~ni & wrq;
        st_n   = acc_wr ? WR_HI : RD_HI;
      end
      RD_HI: if (bus_ok) st_n = hi ? RD_LO : IDLE;
      RD_LO: if (bus_ok) st_n = IDLE;
      WR_HI: if (bus_ok) st_n = hi ? WR_LO : IDLE;
      WR_LO: if (bus_ok) st_n = IDLE;
      default: st_n = IDLE;
    endcase
    if (st != IDLE && !bus_ok && cnt == TLIM) begin
      tmo  = 1'b1;
      st_n = IDLE;
    end
  end

  // Sequencer registers; everything holds while cen is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= 8'd0;
      buserror <= 1'b0;
      op       <= 8'h00;
      mdata    <= 16'h0000;
      bus_addr <= 16'h0000;
      bus_dout <= 8'h00;
      fetch    <= 1'b0;
      hi       <= 1'b0;
      wlo      <= 8'h00;
      hold     <= 8'h00;
    end else if (cen) begin
      st       <= st_n;
      buserror <= tmo;
      if (st_n != st)
        cnt <= 8'd0;
      else if (bus_cs && !bus_ok)
        cnt <= cnt + 8'd1;
      if (acc) begin
        fetch    <= ni;
        hi       <= memhi & ~ni;
        bus_addr <= addr;
        wlo      <= dout[7:0];
        if (acc_wr)
          bus_dout <= memhi ? dout[15:8] : dout[7:0];
      end
      if (bus_ok) begin
        case (st)
          RD_HI: begin
            if (fetch)
              op <= din;
            else if (hi) begin
              hold     <= din;
              bus_addr <= bus_addr + 16'd1;
            end else
              mdata <= {8'h00, din};
          end
          RD_LO: mdata <= {hold, din};
          WR_HI: if (hi) begin
            bus_addr <= bus_addr + 16'd1;
            bus_dout <= wlo;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_bus.sv
// Directed bench for jtkcpu_bus: per-cycle vector table plus
// hand-written reset and request-cycle checks.
module tb_jtkcpu_bus;

  logic        rst, clk, cen;
  logic [15:0] addr, dout;
  logic        ni, opd, wrq, memhi;
  logic [7:0]  op;
  logic [15:0] mdata;
  logic        mem_busy, buserror, bus_cs, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, din;
  logic        bus_ok;

  int n_cmp = 0;
  int n_bad = 0;

  jtkcpu_bus #(.TIMEOUT(4)) dut (
    .rst(rst), .clk(clk), .cen(cen), .addr(addr),
    .ni(ni), .opd(opd), .wrq(wrq), .memhi(memhi),
    .dout(dout), .op(op), .mdata(mdata),
    .mem_busy(mem_busy), .buserror(buserror),
    .bus_cs(bus_cs), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_dout(bus_dout),
    .din(din), .bus_ok(bus_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c, n, o, w, m;
    logic [15:0] a, d;
    logic [7:0]  di;
    logic        ok;
    logic [51:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [51:0] ex(
    input logic cs, we, input logic [15:0] ba,
    input logic [7:0] bd, o, input logic [15:0] md,
    input logic busy, err);
    return {cs, we, ba, bd, o, md, busy, err};
  endfunction

  function automatic logic [51:0] outs();
    return {bus_cs, bus_we, bus_addr, bus_dout,
            op, mdata, mem_busy, buserror};
  endfunction

  task automatic add(
    input logic c, n, o, w, m,
    input logic [15:0] a, d, input logic [7:0] di,
    input logic ok, input logic [51:0] e);
    vec_t v;
    v.c = c; v.n = n; v.o = o; v.w = w; v.m = m;
    v.a = a; v.d = d; v.di = di; v.ok = ok; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [51:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, n, o, w, m,
                       input logic [15:0] a, d,
                       input logic [7:0] di, input logic ok);
    cen = c; ni = n; opd = o; wrq = w; memhi = m;
    addr = a; dout = d; din = di; bus_ok = ok;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 8'h0, 1);
    // fetch
    add(1,1,0,0,0,16'h1234,16'h0,8'h86,1,
        ex(1,0,16'h1234,8'h00,8'h00,16'h0000,1,0));
    add(1,0,0,0,0,16'h1234,16'h0,8'h86,1,
        ex(0,0,16'h1234,8'h00,8'h86,16'h0000,0,0));
    // 16-bit read across the FFFFh wrap
    add(1,0,1,0,1,16'hFFFF,16'h0,8'h00,1,
        ex(1,0,16'hFFFF,8'h00,8'h86,16'h0000,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h12,1,
        ex(1,0,16'h0000,8'h00,8'h86,16'h0000,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h34,1,
        ex(0,0,16'h0000,8'h00,8'h86,16'h1234,0,0));
    // 16-bit write, three wait cycles per byte, one cen-low hold
    add(1,0,0,1,1,16'h2000,16'hABCD,8'h00,0,
        ex(1,1,16'h2000,8'hAB,8'h86,16'h1234,1,0));
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,16'h0,16'h0,8'h00,0,
          ex(1,1,16'h2000,8'hAB,8'h86,16'h1234,1,0));
    add(0,0,0,0,0,16'h0,16'h0,8'h00,1,
        ex(1,1,16'h2000,8'hAB,8'h86,16'h1234,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h00,1,
        ex(1,1,16'h2001,8'hCD,8'h86,16'h1234,1,0));
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,16'h0,16'h0,8'h00,0,
          ex(1,1,16'h2001,8'hCD,8'h86,16'h1234,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h00,1,
        ex(0,0,16'h2001,8'hCD,8'h86,16'h1234,0,0));
    // priority: ni wins, no write
    add(1,1,1,1,1,16'h3000,16'hFFFF,8'h00,1,
        ex(1,0,16'h3000,8'hCD,8'h86,16'h1234,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h5A,1,
        ex(0,0,16'h3000,8'hCD,8'h5A,16'h1234,0,0));
    // timeout after 4 stalled cen cycles
    add(1,0,1,0,0,16'h4000,16'h0,8'h00,0,
        ex(1,0,16'h4000,8'hCD,8'h5A,16'h1234,1,0));
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,16'h0,16'h0,8'h00,0,
          ex(1,0,16'h4000,8'hCD,8'h5A,16'h1234,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h00,0,
        ex(0,0,16'h4000,8'hCD,8'h5A,16'h1234,0,1));
    add(1,0,0,0,0,16'h0,16'h0,8'h00,0,
        ex(0,0,16'h4000,8'hCD,8'h5A,16'h1234,0,0));
    // back-to-back 8-bit reads
    add(1,0,1,0,0,16'h4100,16'h0,8'h00,1,
        ex(1,0,16'h4100,8'hCD,8'h5A,16'h1234,1,0));
    add(1,0,1,0,0,16'h4200,16'h0,8'h9C,1,
        ex(0,0,16'h4100,8'hCD,8'h5A,16'h009C,1,0));
    add(1,0,1,0,0,16'h4200,16'h0,8'h3E,1,
        ex(1,0,16'h4200,8'hCD,8'h5A,16'h009C,1,0));
    add(1,0,0,0,0,16'h0,16'h0,8'h3E,1,
        ex(0,0,16'h4200,8'hCD,8'h5A,16'h003E,0,0));

    // reset state, with a request pending
    ni = 1'b1;
    #12;
    chk("reset_state", outs(),
        ex(0,0,16'h0,8'h00,8'h00,16'h0000,0,0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("req_cycle_busy", {51'd0, mem_busy}, 52'd1);
    ni = 1'b0;
    #1;
    chk("idle_not_busy", {51'd0, mem_busy}, 52'd0);
    @(negedge clk);

    foreach (tv[i]) begin
      drive(tv[i].c, tv[i].n, tv[i].o, tv[i].w, tv[i].m,
            tv[i].a, tv[i].d, tv[i].di, tv[i].ok);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end

    // reset in the middle of WR_LO
    drive(1, 0, 0, 1, 1, 16'h5000, 16'hBEEF, 8'h00, 1);
    @(posedge clk); @(negedge clk);
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 8'h00, 1);
    @(posedge clk); @(negedge clk);
    chk("wr_lo_entry", outs(),
        ex(1,1,16'h5001,8'hEF,8'h5A,16'h003E,1,0));
    bus_ok = 1'b0;
    ni = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {49'd0, bus_cs, bus_we, mem_busy}, 52'd0);
    @(negedge clk);
    ni = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_release", outs(),
        ex(0,0,16'h0,8'h00,8'h00,16'h0000,0,0));
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 16'h0010, 16'h0, 8'h77, 1);
    @(posedge clk); @(negedge clk);
    chk("post_rst_acc", outs(),
        ex(1,0,16'h0010,8'h00,8'h00,16'h0000,1,0));
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 8'h77, 1);
    @(posedge clk); @(negedge clk);
    chk("post_rst_rd", outs(),
        ex(0,0,16'h0010,8'h00,8'h00,16'h0077,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
